dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory of the RISC-V processor between the core load/store unit (port 0) and a debug/loader port (port 1). It serialises requests with round-robin fairness, drives the memory with registered control, and returns one response per accepted request. It also rejects out-of-range addresses without touching memory. The block sits between the core's memory stage, the debug master and the `data_mem` array.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arbiter_rr.sv | 12 +
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
// Holds the FSM state type, requester port indices and default geometry.
package dmem_arb_pkg;

  localparam int DEF_AW    = 10;
  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 1024;

  localparam int PORT_CORE = 0;
  localparam int PORT_DBG  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational 2-way round-robin picker.
// On a tie the port that did not win last time is granted.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises core and debug accesses onto the single-port data memory.
// Each accepted request takes IDLE -> ACCESS -> RESP, one cycle each.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      resp_valid,
  output logic            resp_err,
  output logic [DW-1:0]   resp_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  // One extra bit so DEPTH == 2**AW is representable.
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  state_t          state;
  logic            last;
  logic            owner;
  logic            we_q;
  logic            err_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [1:0]      gnt;
  logic            sel;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            out_of_range;
  logic            handshake;

  rr_arbiter_2 u_rr (
    .req  (req_valid),
    .last (last),
    .gnt  (gnt)
  );

  assign sel          = gnt[1];
  assign sel_we       = sel ? req_we[1] : req_we[0];
  assign sel_addr     = sel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
  assign sel_wdata    = sel ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  assign handshake    = (state == IDLE) && (gnt != 2'b00);
  assign out_of_range = {1'b0, addr_q} >= DEPTH_LIM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            owner   <= sel;
            last    <= sel;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            err_q   <= 1'b0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          err_q <= out_of_range;
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Out-of-range accesses never reach the memory; their read data is forced to zero.
  always_comb begin
    req_ready  = (state == IDLE) ? gnt : 2'b00;
    mem_en     = (state == ACCESS) && !out_of_range;
    mem_we     = mem_en && we_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    resp_valid = 2'b00;
    resp_err   = 1'b0;
    resp_rdata = '0;
    if (state == RESP) begin
      resp_valid[PORT_CORE] = (owner == 1'(PORT_CORE));
      resp_valid[PORT_DBG]  = (owner == 1'(PORT_DBG));
      resp_err              = err_q;
      if (!we_q && !err_q) begin
        resp_rdata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0]      req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      resp_valid;
  logic            resp_err;
  logic [DW-1:0]   resp_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  int vec_count = 0;
  int miscompares = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: read data appears the cycle after mem_en.
  logic [DW-1:0] mem [0:2047];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } txn_t;

  txn_t tbl [8];
  logic [DW-1:0] ref_mem [0:31];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated transaction from IDLE; returns positioned in the RESP cycle.
  task automatic applyStimulus(input txn_t t);
    logic [1:0] onehot;
    onehot = t.port ? 2'b10 : 2'b01;
    @(negedge clk);
    req_valid = onehot;
    req_we    = {t.we, t.we};
    req_addr  = {t.addr, t.addr};
    req_wdata = {t.wdata, t.wdata};
    #1;
    checkOutput("ready_same_cycle", 64'(req_ready), 64'(onehot));
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checkOutput("access_mem_en", 64'(mem_en), 64'(!t.exp_err));
    checkOutput("access_mem_we", 64'(mem_we), 64'(t.we && !t.exp_err));
    checkOutput("access_mem_addr", 64'(mem_addr), 64'(t.addr));
    if (t.we) checkOutput("access_mem_wdata", 64'(mem_wdata), 64'(t.wdata));
    checkOutput("access_no_resp", 64'(resp_valid), 64'(0));
    checkOutput("access_ready_low", 64'(req_ready), 64'(0));
    @(negedge clk);
    #1;
    checkOutput("resp_valid", 64'(resp_valid), 64'(onehot));
    checkOutput("resp_err", 64'(resp_err), 64'(t.exp_err));
    checkOutput("resp_rdata", 64'(resp_rdata), 64'(t.exp_rdata));
    checkOutput("resp_mem_en_low", 64'(mem_en), 64'(0));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    checkOutput({tag, "_resp_err"}, 64'(resp_err), 64'(0));
    checkOutput({tag, "_resp_rdata"}, 64'(resp_rdata), 64'(0));
    checkOutput({tag, "_mem_en"}, 64'(mem_en), 64'(0));
    checkOutput({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    checkOutput({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
  endtask

  initial begin
    int g_cycle [8];
    logic g_port [8];
    int n;
    int k;
    int hs [4];
    int busy;
    logic m_last, m_owner, m_err, m_we, gp;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] m_addr;
    logic [1:0] pend, p_we, exp_ready;
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wdata [2];
    txn_t t;

    tbl[0] = '{1'b0, 1'b1, 11'd5,    32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 11'd5,    32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 1'b0, 11'd1024, 32'h0,        1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 11'd1023, 32'hCAFEF00D, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 11'd1023, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[5] = '{1'b1, 1'b1, 11'd2047, 32'h12345678, 1'b1, 32'h0};
    tbl[6] = '{1'b0, 1'b1, 11'd1500, 32'h87654321, 1'b1, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 11'd1023, 32'h0,        1'b0, 32'hCAFEF00D};

    doReset();
    #1;
    checkOutput("reset_ready_idle", 64'(req_ready), 64'(0));
    checkResetValues("reset");

    for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);

    // Contention: both ports hold reads from reset; grants must alternate.
    doReset();
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = {11'd1023, 11'd5};
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checkOutput("contention_onehot", 64'($countones(req_ready) <= 1), 64'(1));
      if (req_ready != 2'b00 && n < 8) begin
        g_cycle[n] = c;
        g_port[n]  = req_ready[1];
        n++;
      end
      if (resp_valid == 2'b01) checkOutput("contention_core_rdata", 64'(resp_rdata), 64'(32'hDEADBEEF));
      if (resp_valid == 2'b10) checkOutput("contention_dbg_rdata", 64'(resp_rdata), 64'(32'hCAFEF00D));
    end
    checkOutput("contention_grant_count", 64'(n), 64'(4));
    for (int i = 0; i < 4 && i < n; i++) begin
      checkOutput("contention_grant_cycle", 64'(g_cycle[i]), 64'(3 * i));
      checkOutput("contention_grant_port", 64'(g_port[i]), 64'(i % 2));
    end

    // Mid-operation reset while in ACCESS.
    @(negedge clk);
    req_valid = 2'b01;
    req_we    = 2'b01;
    req_addr  = {11'd0, 11'd9};
    req_wdata = {32'h0, 32'h11111111};
    #1;
    checkOutput("midreset_ready", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checkOutput("midreset_in_access", 64'(mem_en), 64'(1));
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checkOutput("midreset_no_resp", 64'(resp_valid), 64'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = {11'd1023, 11'd5};
    #1;
    checkOutput("postreset_tie_core", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    checkOutput("postreset_resp_valid", 64'(resp_valid), 64'(2'b01));
    checkOutput("postreset_rdata", 64'(resp_rdata), 64'(32'hDEADBEEF));

    // Single requester streaming: four debug writes back to back.
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      @(negedge clk);
      req_valid = 2'b10;
      req_we    = 2'b10;
      req_addr  = {AW'(20 + k), 11'd0};
      req_wdata = {32'hA0A0_0000 + 32'(k), 32'h0};
      #1;
      if (req_ready[1]) begin
        hs[k] = c;
        k++;
      end
    end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("stream_handshakes", 64'(k), 64'(4));
    for (int i = 1; i < 4 && i < k; i++)
      checkOutput("stream_spacing", 64'(hs[i] - hs[0]), 64'(3 * i));
    for (int i = 0; i < 4; i++) begin
      t = '{1'b1, 1'b0, AW'(20 + i), 32'h0, 1'b0, 32'hA0A0_0000 + 32'(i)};
      applyStimulus(t);
    end

    // Prefill the random window with known data.
    for (int i = 0; i < 32; i++) begin
      t = '{1'(i % 2), 1'b1, AW'(512 + i), $urandom, 1'b0, 32'h0};
      ref_mem[i] = t.wdata;
      applyStimulus(t);
    end

    // Randomized traffic against a transaction-level model.
    doReset();
    busy = 0;
    m_last = 1'b1;
    m_owner = 1'b0;
    m_err = 1'b0;
    m_we = 1'b0;
    m_addr = '0;
    m_rdata = '0;
    pend = 2'b00;
    p_we = 2'b00;
    p_addr[0] = '0; p_addr[1] = '0;
    p_wdata[0] = '0; p_wdata[1] = '0;
    for (int c = 0; c < 420; c++) begin
      if (c > 0) @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && c < 400 && $urandom_range(0, 99) < 45) begin
          pend[p]    = 1'b1;
          p_we[p]    = 1'($urandom_range(0, 1));
          p_addr[p]  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(1024, 2047))
                                                   : AW'(512 + $urandom_range(0, 31));
          p_wdata[p] = $urandom;
        end
      end
      req_valid = pend;
      req_we    = p_we;
      req_addr  = {p_addr[1], p_addr[0]};
      req_wdata = {p_wdata[1], p_wdata[0]};
      #1;
      if (busy == 0) exp_ready = (pend == 2'b11) ? (m_last ? 2'b01 : 2'b10) : pend;
      else           exp_ready = 2'b00;
      checkOutput("rand_ready", 64'(req_ready), 64'(exp_ready));
      checkOutput("rand_resp_valid", 64'(resp_valid),
                  64'((busy == 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00));
      checkOutput("rand_mem_en", 64'(mem_en), 64'(busy == 2 && !m_err));
      checkOutput("rand_mem_we", 64'(mem_we), 64'(busy == 2 && !m_err && m_we));
      if (busy == 2 && !m_err) checkOutput("rand_mem_addr", 64'(mem_addr), 64'(m_addr));
      if (busy == 1) begin
        checkOutput("rand_resp_err", 64'(resp_err), 64'(m_err));
        checkOutput("rand_resp_rdata", 64'(resp_rdata), 64'(m_rdata));
      end
      if (busy == 0 && exp_ready != 2'b00) begin
        gp      = exp_ready[1];
        m_owner = gp;
        m_last  = gp;
        m_addr  = p_addr[gp];
        m_we    = p_we[gp];
        m_err   = int'(p_addr[gp]) >= DEPTH;
        m_rdata = '0;
        if (!m_err) begin
          if (m_we) ref_mem[int'(p_addr[gp]) - 512] = p_wdata[gp];
          else      m_rdata = ref_mem[int'(p_addr[gp]) - 512];
        end
        pend[gp] = 1'b0;
        busy = 2;
      end else if (busy > 0) begin
        busy--;
      end
    end
    @(negedge clk);
    req_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
